// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 LSB first; define UART_RX_PARITY_EN for an even-parity bit before stop
module uart_rx #(
  parameter int UART_BPS = 'd9600,
  parameter int CLK_FREQ = 'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       parity_err
);
  localparam logic [15:0] BAUD_CNT = 16'(CLK_FREQ / UART_BPS);
  localparam logic [15:0] MID = BAUD_CNT / 16'd2 - 16'd1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, next;
  logic rx_s1, rx_s2, rx_s3;
  logic [15:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic start_edge, sample_tick, stop_tick, par_bad, good;
  assign start_edge = rx_s3 & ~rx_s2;
  assign sample_tick = (state != IDLE) && (baud_cnt == MID);
  assign stop_tick = sample_tick && (state == STOP);
  assign good = stop_tick & rx_s2 & ~par_bad;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // capture the parity bit at its mid-bit point
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) par_bit <= 1'b0;
    else if (sample_tick && state == PARITY) par_bit <= rx_s2;
  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad = 1'b0;
`endif
  // two-flop synchroniser plus delay flop for falling-edge detection, idle high
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};
  // bit-period counter, held at zero while idle so the first tick lands mid start bit
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) baud_cnt <= '0;
    else baud_cnt <= (state == IDLE || baud_cnt == BAUD_CNT - 16'd1) ? '0 : baud_cnt + 16'd1;
  // data bits shifted in LSB first at each mid-bit sample
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      bit_cnt <= '0;
      shift <= '0;
    end else if (sample_tick && state == START) begin
      bit_cnt <= '0;
    end else if (sample_tick && state == DATA) begin
      shift[bit_cnt] <= rx_s2;
      bit_cnt <= bit_cnt + 3'd1;
    end
  // state register
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= next;
  // next state; return to idle at mid stop bit so a back-to-back start edge is not missed
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start_edge ? START : IDLE;
      START: next = sample_tick ? (rx_s2 ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA: next = (sample_tick && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY: next = sample_tick ? STOP : PARITY;
`else
      DATA: next = (sample_tick && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      STOP: next = sample_tick ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  // registered result strobes; po_data only moves on a good frame
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      po_data <= 8'h00;
      po_flag <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      po_flag <= good;
      frame_err <= stop_tick & ~rx_s2;
      parity_err <= stop_tick & par_bad;
      if (good) po_data <= shift;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at BAUD_CNT=10
module tb_uart_rx;
  localparam int BAUD = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = 9 * BAUD + BAUD / 2 + 3 + (PAR ? BAUD : 0);
  localparam logic [2:0] F = 3'b001;
  localparam logic [2:0] E = 3'b010;
  localparam logic [2:0] P = 3'b100;
  typedef struct {
    logic [2:0] code;
    logic [7:0] data;
    int t;
  } exp_t;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic rx;
  logic [7:0] po_data;
  logic po_flag, frame_err, parity_err;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [2:0] prev = 3'b000;
  uart_rx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx(rx),
    .po_data(po_data),
    .po_flag(po_flag),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  // monitor: every strobe must match the next scoreboard entry in kind, data and timing
  always @(negedge sys_clk) begin
    logic [2:0] code;
    exp_t e;
    code = {parity_err, frame_err, po_flag};
    if (code != 3'b000) begin
      tests++;
      if (prev != 3'b000) begin
        fails++;
        $display("FAIL pulse_width: strobes %b high again at cycle %0d, required single-cycle", code, cyc);
      end
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got strobes %b data %h at cycle %0d, required none", code, po_data, cyc);
      end else begin
        e = q.pop_front();
        if (code !== e.code || po_data !== e.data || cyc < e.t - 4 || cyc > e.t + 4) begin
          fails++;
          $display("FAIL frame: got strobes %b data %h cycle %0d, required strobes %b data %h cycle %0d+-4",
                   code, po_data, cyc, e.code, e.data, e.t);
        end
      end
    end
    prev = code;
  end
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic bit_time(input logic v);
    rx = v;
    repeat (BAUD) @(negedge sys_clk);
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic flip,
                      input logic [2:0] code, input logic [7:0] exp_data);
    q.push_back('{code, exp_data, cyc + LAT});
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (PAR) bit_time(^d ^ flip);
    bit_time(stop);
  endtask
  initial begin
    rx = 1'b1;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_data", po_data, 8'h00);
    check("reset_strobes", {5'b0, parity_err, frame_err, po_flag}, 8'h00);
    sys_rst_n = 1'b1;
    idle(5);
    send(8'h55, 1'b1, 1'b0, F, 8'h55);
    idle(20);
    send(8'hA3, 1'b1, 1'b0, F, 8'hA3);
    send(8'h0F, 1'b1, 1'b0, F, 8'h0F);
    idle(20);
    rx = 1'b0;
    repeat (3) @(negedge sys_clk);
    idle(30);
    send(8'h81, 1'b1, 1'b0, F, 8'h81);
    idle(20);
    send(8'h3C, 1'b0, 1'b0, E, 8'h81);
    idle(30);
    send(8'hC3, 1'b1, 1'b0, F, 8'hC3);
    idle(20);
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("midframe_reset_data", po_data, 8'h00);
    sys_rst_n = 1'b1;
    idle(20);
    send(8'h12, 1'b1, 1'b0, F, 8'h12);
    idle(20);
    if (PAR) begin
      send(8'h01, 1'b1, 1'b0, F, 8'h01);
      idle(20);
      send(8'h01, 1'b1, 1'b1, P, 8'h01);
      idle(20);
    end
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge sys_clk);
    check("queue_drained", 8'(q.size()), 8'h00);
    check("final_data", po_data, PAR ? 8'h01 : 8'h12);
    repeat (5) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at cycle %0d, required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
